// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with one shared counter, edge- or center-aligned counting,
// and shadowed period/duty registers committed only at period boundaries.
module pwm_multichannel #(
  parameter int WIDTH        = 4,
  parameter int CHANNELS     = 4,
  parameter int RESET_PERIOD = 7,
  parameter int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic                period_we,
  input  logic [WIDTH-1:0]    period_data,
  input  logic                duty_we,
  input  logic [SEL_W-1:0]    duty_sel,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                update_pending
);

  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(CHANNELS);
  localparam logic           DIR_UP    = 1'b0;
  localparam logic           DIR_DOWN  = 1'b1;

  logic             run_q, run_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;

  logic boundary;
  logic commit;
  logic duty_ok;
  logic any_write;

  always_comb begin
    boundary = 1'b0;
    if (run_q) begin
      if (mode_q) begin
        boundary = (period_act_q == '0) || ((cnt_q == '0) && (dir_q == DIR_DOWN));
      end else begin
        boundary = (cnt_q == period_act_q);
      end
    end
  end

  // While idle the active set tracks the shadows every cycle.
  assign commit    = !run_q || boundary;
  assign duty_ok   = duty_we && ({1'b0, duty_sel} < SEL_LIMIT);
  assign any_write = period_we || duty_ok;

  always_comb begin
    run_d        = enable;
    mode_d       = mode;
    period_sh_d  = period_we ? period_data : period_sh_q;
    period_act_d = commit ? period_sh_q : period_act_q;
    pending_d    = pending_q;
    if (any_write) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (run_q && enable) begin
      if (!mode_q) begin
        cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
      end else if (boundary) begin
        // The bottom of the triangle is shared by both periods; next step is 1.
        cnt_d = (period_sh_q == '0) ? '0 : WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == period_act_q) begin
          cnt_d = cnt_q - WIDTH'(1);
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        dir_d = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= 1'b0;
      mode_q       <= 1'b0;
      dir_q        <= DIR_UP;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      period_sh_q  <= WIDTH'(RESET_PERIOD);
      period_act_q <= WIDTH'(RESET_PERIOD);
    end else begin
      run_q        <= run_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;

    always_comb begin
      duty_sh_d = duty_sh_q;
      if (duty_ok && (duty_sel == SEL_W'(gi))) begin
        duty_sh_d = duty_data;
      end
      duty_act_d = commit ? duty_sh_q : duty_act_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
      end else begin
        duty_sh_q  <= duty_sh_d;
        duty_act_q <= duty_act_d;
      end
    end

    assign pwm_out[gi] = run_q && (cnt_q < duty_act_q);
  end

  assign period_tick    = boundary;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a phase-based reference model checked every
// cycle, plus literal expectations on waveform shapes and period lengths.
module tb_pwm_multichannel;

  localparam int WIDTH = 4;
  localparam int CH    = 3;
  localparam int RP    = 7;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             mode;
  logic             period_we;
  logic [WIDTH-1:0] period_data;
  logic             duty_we;
  logic [SEL_W-1:0] duty_sel;
  logic [WIDTH-1:0] duty_data;
  logic [CH-1:0]    pwm_out;
  logic             period_tick;
  logic             update_pending;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  pwm_multichannel #(
    .WIDTH(WIDTH), .CHANNELS(CH), .RESET_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .period_we(period_we), .period_data(period_data),
    .duty_we(duty_we), .duty_sel(duty_sel), .duty_data(duty_data),
    .pwm_out(pwm_out), .period_tick(period_tick), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period is a phase; in center mode the
  // counter value is the triangle fold of that phase over [0, 2*period).
  bit m_run, m_mode, m_started, m_pend;
  int m_ph, m_psh, m_pact;
  int m_dsh[CH];
  int m_dact[CH];

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_started = 0; m_pend = 0;
    m_ph = 0; m_psh = RP; m_pact = RP;
    for (int i = 0; i < CH; i++) begin
      m_dsh[i] = 0;
      m_dact[i] = 0;
    end
  endtask

  function automatic int m_cnt();
    if (m_mode && m_ph > m_pact) return 2 * m_pact - m_ph;
    return m_ph;
  endfunction

  function automatic bit m_bnd();
    if (!m_run) return 1'b0;
    if (m_mode) return (m_pact == 0) || (m_ph == 0 && m_started);
    return m_ph == m_pact;
  endfunction

  function automatic logic [CH-1:0] m_pwm();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_run && (m_cnt() < m_dact[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm()));
      chk("period_tick", 32'(period_tick), 32'(m_bnd()));
      chk("update_pending", 32'(update_pending), 32'(m_pend));
    end
  end

  // Advance one clock: predict from pre-edge inputs, apply after the edge.
  task automatic tick();
    bit bnd, com, wr, n_start;
    int n_psh, n_pact, n_ph, n_p;
    int n_dsh[CH];
    int n_dact[CH];
    bit live;
    live = reset;
    bnd = m_bnd();
    com = !m_run || bnd;
    wr  = period_we || (duty_we && int'(duty_sel) < CH);
    n_psh  = period_we ? int'(period_data) : m_psh;
    n_pact = com ? m_psh : m_pact;
    for (int i = 0; i < CH; i++) begin
      n_dsh[i]  = (duty_we && int'(duty_sel) == i) ? int'(duty_data) : m_dsh[i];
      n_dact[i] = com ? m_dsh[i] : m_dact[i];
    end
    if (!enable || !m_run) begin
      n_ph = 0; n_start = 0;
    end else if (!m_mode) begin
      n_ph = bnd ? 0 : m_ph + 1; n_start = 0;
    end else begin
      n_p = com ? m_psh : m_pact;
      n_ph = (n_p == 0) ? 0 : (m_ph + 1) % (2 * n_p);
      n_start = 1;
    end
    @(posedge clk);
    if (live && reset) begin
      m_pend = wr ? 1'b1 : (com ? 1'b0 : m_pend);
      m_run = enable; m_mode = mode;
      m_psh = n_psh; m_pact = n_pact;
      m_ph = n_ph; m_started = n_start;
      for (int i = 0; i < CH; i++) begin
        m_dsh[i] = n_dsh[i];
        m_dact[i] = n_dact[i];
      end
    end
    #1;
  endtask

  task automatic write_duty(input int sel, input int data);
    duty_sel = SEL_W'(sel); duty_data = WIDTH'(data); duty_we = 1'b1;
    tick();
    duty_we = 1'b0;
  endtask

  task automatic write_period(input int p);
    period_data = WIDTH'(p); period_we = 1'b1;
    tick();
    period_we = 1'b0;
  endtask

  task automatic wait_tick_pass();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (period_tick) found = 1'b1;
      tick();
    end
    chk("wait_tick", 32'(found), 32'd1);
  endtask

  task automatic wait_boundary();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (period_tick) found = 1'b1;
      else tick();
    end
    chk("wait_boundary", 32'(found), 32'd1);
  endtask

  task automatic measure_period(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      n++;
      if (period_tick) found = 1'b1;
      tick();
    end
    if (!found) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p16, t16;
    logic [7:0]  p8;
    logic        or0, and1, and0, andt;
    int          n;

    reset = 1'b0; enable = 1'b0; mode = 1'b0;
    period_we = 1'b0; period_data = '0;
    duty_we = 1'b0; duty_sel = '0; duty_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    check_en = 1'b1;
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);
    chk("reset_pending", 32'(update_pending), 32'd0);

    // Edge mode, default period 7, duty ch0 = 4
    write_duty(0, 4);
    tick();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      p16[k] = pwm_out[0]; t16[k] = period_tick;
      tick();
    end
    $display("edge ch0 duty4: pwm=%h tick=%h", p16, t16);
    chk("t1_ch0_pattern", 32'(p16), 32'h0F0F);
    chk("t1_tick_pattern", 32'(t16), 32'h8080);

    // Duty write mid-period is held until the boundary
    tick(); tick();
    write_duty(1, 6);
    chk("t2_pending_set", 32'(update_pending), 32'd1);
    wait_tick_pass();
    chk("t2_pending_clear", 32'(update_pending), 32'd0);
    for (int k = 0; k < 8; k++) begin
      p8[k] = pwm_out[1];
      tick();
    end
    $display("ch1 after commit: pwm=%h", p8);
    chk("t2_ch1_pattern", 32'(p8), 32'h3F);

    // Period write in the boundary cycle lands one boundary later
    wait_boundary();
    write_period(3);
    chk("t3_pending_held", 32'(update_pending), 32'd1);
    measure_period(n);
    $display("period after boundary write: %0d", n);
    chk("t3_period_a", 32'(n), 32'd8);
    measure_period(n);
    $display("period after that: %0d", n);
    chk("t3_period_b", 32'(n), 32'd4);

    // Center mode, period 4, duty ch2 = 2 (period and duty written together)
    enable = 1'b0; mode = 1'b1;
    tick();
    period_we = 1'b1; period_data = 4'd4;
    duty_we = 1'b1; duty_sel = 2'd2; duty_data = 4'd2;
    tick();
    period_we = 1'b0; duty_we = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      p16[k] = pwm_out[2]; t16[k] = period_tick;
      tick();
    end
    $display("center ch2 duty2: pwm=%h tick=%h", p16, t16);
    chk("t4_ch2_pattern", 32'(p16), 32'h8383);
    chk("t4_tick_pattern", 32'(t16), 32'h0100);

    // Duty 0 and duty period+1
    enable = 1'b0; mode = 1'b0;
    tick();
    write_period(5);
    write_duty(0, 0);
    write_duty(1, 6);
    tick();
    enable = 1'b1;
    tick();
    or0 = 1'b0; and1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      or0 |= pwm_out[0]; and1 &= pwm_out[1];
      tick();
    end
    $display("duty0 any-high=%0b dutyP+1 all-high=%0b", or0, and1);
    chk("t5_duty0_low", 32'(or0), 32'd0);
    chk("t5_dutyP1_high", 32'(and1), 32'd1);

    // Degenerate period 0
    enable = 1'b0;
    tick();
    write_period(0);
    write_duty(0, 1);
    tick();
    enable = 1'b1;
    tick();
    and0 = 1'b1; andt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      and0 &= pwm_out[0]; andt &= period_tick;
      tick();
    end
    $display("period0: ch0 all-high=%0b tick all-high=%0b", and0, andt);
    chk("t5_p0_ch0_high", 32'(and0), 32'd1);
    chk("t5_p0_tick_high", 32'(andt), 32'd1);

    // Out-of-range duty write then async reset mid-period
    enable = 1'b0;
    tick();
    write_period(7);
    tick();
    enable = 1'b1;
    tick(); tick(); tick();
    write_duty(3, 9);
    chk("t6_oor_no_pending", 32'(update_pending), 32'd0);
    chk("t6_ch1_high_before", 32'(pwm_out[1]), 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    $display("async reset: pwm=%0d tick=%0d pending=%0d", pwm_out, period_tick, update_pending);
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_tick", 32'(period_tick), 32'd0);
    chk("t6_rst_pending", 32'(update_pending), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_ch1_after_reset", 32'(pwm_out[1]), 32'd0);
    write_duty(1, 3);
    for (int k = 0; k < 20; k++) tick();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
